// File: rtl/map_write_arbiter.sv
// map_write_arbiter: funnels tile writes from several requesters (two bomb
// units and the explosion engine) into the single write port of the map RAM.
// Each requester has its own small queue. A round-robin arbiter drains at most
// one queue per cycle into registered RAM-port outputs.
module map_write_arbiter #(
  parameter int NUM_ROW       = 11,
  parameter int NUM_COL       = 19,
  parameter int MAP_MEM_WIDTH = 2,
  parameter int NUM_REQ       = 3,
  parameter int FIFO_DEPTH    = 2,
  localparam int ADDR_WIDTH   = $clog2(NUM_ROW * NUM_COL),
  localparam int SRC_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*MAP_MEM_WIDTH-1:0]   req_data,
  input  logic                               clear_overflow,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [MAP_MEM_WIDTH-1:0]           mem_data,
  output logic                               mem_we,
  output logic [SRC_WIDTH-1:0]               mem_src,
  output logic [NUM_REQ-1:0]                 overflow,
  output logic                               busy
);

  // FIFO_DEPTH is a power of two, so the read and write pointers wrap on
  // their own. The occupancy counter needs one extra bit to represent "full".
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [MAP_MEM_WIDTH-1:0] data;
  } entry_t;

  entry_t                 fifo_mem [NUM_REQ][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr   [NUM_REQ];
  logic [PTR_WIDTH-1:0]   rd_ptr   [NUM_REQ];
  logic [CNT_WIDTH-1:0]   count    [NUM_REQ];

  logic [NUM_REQ-1:0]     not_empty;
  logic [NUM_REQ-1:0]     full;
  logic [NUM_REQ-1:0]     pop;
  logic [NUM_REQ-1:0]     push;
  logic [NUM_REQ-1:0]     drop;

  logic                   gnt_valid;
  logic [SRC_WIDTH-1:0]   gnt_idx;
  logic [SRC_WIDTH-1:0]   rr_ptr;
  entry_t                 head;

  // Queue status, derived only from registered occupancy. A queue that is
  // empty before the edge is therefore never granted in the same cycle it is
  // pushed, so there is no bypass path from request to RAM port.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    not_empty = '0;
    full      = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      not_empty[j] = (count[j] != '0);
      full[j]      = (count[j] == CNT_WIDTH'(FIFO_DEPTH));
    end
  end

  // Round-robin pick: the first non-empty queue at or above rr_ptr wins,
  // otherwise the search wraps around to the lowest non-empty index.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_valid && not_empty[j] && (SRC_WIDTH'(j) >= rr_ptr)) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_valid && not_empty[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SRC_WIDTH'(j);
      end
    end
  end

  // Per-queue pop/push/drop decisions. A full queue that is popped this cycle
  // frees the slot the incoming entry needs, so that push still succeeds.
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pop[j]  = gnt_valid && (gnt_idx == SRC_WIDTH'(j));
      push[j] = req_en[j] && (!full[j] || pop[j]);
      drop[j] = req_en[j] && full[j] && !pop[j];
    end
  end

  // Head entry of the granted queue, which feeds the RAM-port registers.
  always_comb begin
    head = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == SRC_WIDTH'(j)) begin
        head = fifo_mem[j][rd_ptr[j]];
      end
    end
  end

  // Queue storage: write the requester's address and data slices at the tail.
  // NOTE: the storage array has no reset. Emptiness is tracked by the
  // pointers and counters, so stale entries are never read, and leaving the
  // array out of reset allows it to map onto plain RAM or register files.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i]] <= '{addr: req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                    data: req_data[i*MAP_MEM_WIDTH +: MAP_MEM_WIDTH]};
      end
    end
  end

  // Queue pointers and occupancy. Reset empties every queue and overrides any
  // request that arrives in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_WIDTH'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_WIDTH'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_WIDTH'(1);
          2'b01:   count[i] <= count[i] - CNT_WIDTH'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered RAM write port and round-robin pointer. On a grant, the head
  // entry is loaded and the pointer moves just past the winner. When there is
  // no grant, only the write enable drops and the address/data/source hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_src  <= '0;
    end else if (gnt_valid) begin
      mem_we   <= 1'b1;
      mem_addr <= head.addr;
      mem_data <= head.data;
      mem_src  <= gnt_idx;
      rr_ptr   <= (gnt_idx == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_WIDTH'(1);
    end else begin
      mem_we   <= 1'b0;
    end
  end

  // Sticky drop flags. A drop in the same cycle as clear_overflow still sets
  // its bit, so no drop is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= '0;
    end else begin
      overflow <= (clear_overflow ? '0 : overflow) | drop;
    end
  end

  assign busy = |not_empty;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter at default parameters. Inputs change
// 1 ns after each rising edge, and outputs are sampled at that same point.
module tb_map_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_en;
  logic [23:0] req_addr;
  logic [5:0]  req_data;
  logic        clear_overflow;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_data;
  logic        mem_we;
  logic [1:0]  mem_src;
  logic [2:0]  overflow;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  map_write_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_en         (req_en),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .clear_overflow (clear_overflow),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_we         (mem_we),
    .mem_src        (mem_src),
    .overflow       (overflow),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_en         = '0;
    req_addr       = '0;
    req_data       = '0;
    clear_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  // Reset state, and reset taking priority over simultaneous requests.
  task automatic test_reset();
    rst      = 1'b1;
    req_en   = 3'b111;
    req_addr = {8'd30, 8'd20, 8'd10};
    req_data = 6'b111111;
    clear_overflow = 1'b0;
    tick();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL reset_we: got %0b want 0", mem_we); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_compared++; if (overflow !== 3'b000) begin n_mismatched++; $display("FAIL reset_overflow: got %b want 000", overflow); end
    n_compared++; if (mem_addr !== 8'd0) begin n_mismatched++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    n_compared++; if (mem_data !== 2'd0) begin n_mismatched++; $display("FAIL reset_data: got %0d want 0", mem_data); end
    n_compared++; if (mem_src !== 2'd0) begin n_mismatched++; $display("FAIL reset_src: got %0d want 0", mem_src); end
    rst = 1'b0;
    idle_inputs();
    tick();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL reset_prio_we: got %0b want 0", mem_we); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_prio_busy: got %0b want 0", busy); end
  endtask

  // One request: two-cycle latency, then address/data hold once idle.
  task automatic test_single();
    do_reset();
    req_en   = 3'b001;
    req_addr = {8'd0, 8'd0, 8'd22};
    req_data = {2'd0, 2'd0, 2'd3};
    tick();
    idle_inputs();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL single_nobypass_we: got %0b want 0", mem_we); end
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("FAIL single_busy_q: got %0b want 1", busy); end
    tick();
    n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("FAIL single_we: got %0b want 1", mem_we); end
    n_compared++; if (mem_addr !== 8'd22) begin n_mismatched++; $display("FAIL single_addr: got %0d want 22", mem_addr); end
    n_compared++; if (mem_data !== 2'd3) begin n_mismatched++; $display("FAIL single_data: got %0d want 3", mem_data); end
    n_compared++; if (mem_src !== 2'd0) begin n_mismatched++; $display("FAIL single_src: got %0d want 0", mem_src); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL single_busy_done: got %0b want 0", busy); end
    tick();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL single_we_off: got %0b want 0", mem_we); end
    n_compared++; if (mem_addr !== 8'd22) begin n_mismatched++; $display("FAIL single_addr_hold: got %0d want 22", mem_addr); end
  endtask

  // All three requesters strobe together: three back-to-back writes 0,1,2.
  task automatic test_simultaneous();
    do_reset();
    req_en   = 3'b111;
    req_addr = {8'd30, 8'd20, 8'd10};
    req_data = {2'd3, 2'd2, 2'd1};
    tick();
    idle_inputs();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL sim_we_first: got %0b want 0", mem_we); end
    for (int g = 0; g < 3; g++) begin
      tick();
      n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("FAIL sim_we[%0d]: got %0b want 1", g, mem_we); end
      n_compared++; if (mem_src !== 2'(g)) begin n_mismatched++; $display("FAIL sim_src[%0d]: got %0d want %0d", g, mem_src, g); end
      n_compared++; if (mem_addr !== 8'((g + 1) * 10)) begin n_mismatched++; $display("FAIL sim_addr[%0d]: got %0d want %0d", g, mem_addr, (g + 1) * 10); end
      n_compared++; if (mem_data !== 2'(g + 1)) begin n_mismatched++; $display("FAIL sim_data[%0d]: got %0d want %0d", g, mem_data, g + 1); end
      n_compared++; if (busy !== (g < 2)) begin n_mismatched++; $display("FAIL sim_busy[%0d]: got %0b want %0b", g, busy, g < 2); end
    end
    tick();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL sim_we_end: got %0b want 0", mem_we); end
  endtask

  // Requesters 0 and 2 strobe for 8 cycles: alternating grants, both overflow.
  task automatic test_round_robin();
    int exp_src  [11] = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 0};
    int exp_addr [11] = '{100, 200, 101, 201, 102, 202, 103, 204, 105, 206, 107};
    do_reset();
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        req_en   = 3'b101;
        req_addr = {8'(200 + n), 8'd0, 8'(100 + n)};
      end else begin
        idle_inputs();
      end
      tick();
      if (n == 0) begin
        n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL rr_we_first: got %0b want 0", mem_we); end
      end else begin
        n_compared++; if (mem_we !== 1'b1) begin n_mismatched++; $display("FAIL rr_we[%0d]: got %0b want 1", n, mem_we); end
        n_compared++; if (mem_src !== 2'(exp_src[n-1])) begin n_mismatched++; $display("FAIL rr_src[%0d]: got %0d want %0d", n, mem_src, exp_src[n-1]); end
        n_compared++; if (mem_addr !== 8'(exp_addr[n-1])) begin n_mismatched++; $display("FAIL rr_addr[%0d]: got %0d want %0d", n, mem_addr, exp_addr[n-1]); end
      end
    end
    n_compared++; if (overflow !== 3'b101) begin n_mismatched++; $display("FAIL rr_overflow: got %b want 101", overflow); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL rr_busy_end: got %0b want 0", busy); end
    tick();
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL rr_we_end: got %0b want 0", mem_we); end
  endtask

  // Requester 1 strobes 4 cycles under saturation: exactly 3 writes get through,
  // and a clear coinciding with a drop leaves the dropped bit set.
  task automatic test_overflow();
    int         cnt1 = 0;
    logic [7:0] got1 [8];
    bit         drained = 1'b0;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      req_en         = {1'b1, (n < 4), 1'b1};
      req_addr       = {8'(200 + n), 8'(50 + n), 8'(100 + n)};
      clear_overflow = (n == 3);
      tick();
      if (mem_we && mem_src == 2'd1) begin
        if (cnt1 < 8) got1[cnt1] = mem_addr;
        cnt1++;
      end
      if (n == 3) begin
        n_compared++; if (overflow !== 3'b011) begin n_mismatched++; $display("FAIL ovf_clear_vs_drop: got %b want 011", overflow); end
      end
    end
    idle_inputs();
    for (int c = 0; c < 20 && !drained; c++) begin
      tick();
      if (mem_we && mem_src == 2'd1) begin
        if (cnt1 < 8) got1[cnt1] = mem_addr;
        cnt1++;
      end
      if (!busy && !mem_we) drained = 1'b1;
    end
    n_compared++; if (drained !== 1'b1) begin n_mismatched++; $display("FAIL ovf_drain_timeout: got %0b want 1", drained); end
    n_compared++; if (cnt1 !== 3) begin n_mismatched++; $display("FAIL ovf_req1_writes: got %0d want 3", cnt1); end
    for (int k = 0; k < 3; k++) begin
      if (k < cnt1) begin
        n_compared++; if (got1[k] !== 8'(50 + k)) begin n_mismatched++; $display("FAIL ovf_req1_order[%0d]: got %0d want %0d", k, got1[k], 50 + k); end
      end
    end
    n_compared++; if (overflow[1] !== 1'b1) begin n_mismatched++; $display("FAIL ovf_flag1: got %0b want 1", overflow[1]); end
    n_compared++; if (overflow !== 3'b111) begin n_mismatched++; $display("FAIL ovf_sticky: got %b want 111", overflow); end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_compared++; if (overflow !== 3'b000) begin n_mismatched++; $display("FAIL ovf_cleared: got %b want 000", overflow); end
  endtask

  // Reset with two entries queued: nothing queued ever reaches the port.
  task automatic test_reset_midstream();
    do_reset();
    req_en   = 3'b011;
    req_addr = {8'd0, 8'd41, 8'd40};
    tick();
    idle_inputs();
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("FAIL mid_busy_queued: got %0b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL mid_we: got %0b want 0", mem_we); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("FAIL mid_busy: got %0b want 0", busy); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_compared++; if (mem_we !== 1'b0) begin n_mismatched++; $display("FAIL mid_we_after[%0d]: got %0b want 0", c, mem_we); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_overflow();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_ROW, 11, map rows.
REQ-002 NUM_COL, 19, map columns.
REQ-003 MAP_MEM_WIDTH, 2, tile code width.
REQ-004 NUM_REQ, 3, requesters: 0 = player-1 bomb_logic, 1 = player-2 bomb_logic, 2 = explosion engine.
REQ-005 FIFO_DEPTH, 2, per-requester queue entries, power of two, at least 2.
REQ-006 Derived: ADDR_WIDTH = $clog2(NUM_ROW*NUM_COL), which is 8 at defaults.
REQ-007 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock; all logic on posedge.
REQ-008 rst, in, 1, synchronous active-high reset.
REQ-009 req_en, in, NUM_REQ, one-cycle write request strobes, one bit per requester.
REQ-010 req_addr, in, NUM_REQ*ADDR_WIDTH, packed tile addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 req_data, in, NUM_REQ*MAP_MEM_WIDTH, packed tile codes, sliced the same way.
REQ-012 clear_overflow, in, 1, clears all overflow flags.
REQ-013 mem_addr, out, ADDR_WIDTH, map RAM write address.
REQ-014 mem_data, out, MAP_MEM_WIDTH, map RAM write data.
REQ-015 mem_we, out, 1, map RAM write enable.
REQ-016 mem_src, out, $clog2(NUM_REQ), index of the requester whose write is on the port.
REQ-017 overflow, out, NUM_REQ, sticky per-requester drop flags.
REQ-018 busy, out, 1, high when any queue is non-empty.

Function
REQ-019 Each requester SHALL own a FIFO_DEPTH-entry FIFO of {addr, data}.
REQ-020 Push: req_en[i] sampled high at a posedge SHALL push that requester's slices into FIFO i.
REQ-021 Full queue: if FIFO i is full and not popped in the same cycle, the request SHALL be dropped and overflow[i] set.
REQ-022 Full queue with same-cycle pop: if FIFO i is full and popped in the same cycle, the push SHALL succeed and the count stays FIFO_DEPTH.
REQ-023 Grant: each cycle at most one non-empty FIFO SHALL be granted and popped, chosen round-robin starting from rr_ptr.
REQ-024 rr_ptr SHALL update to (granted index + 1) mod NUM_REQ after a grant and hold when there is no grant.
REQ-025 Output registers: on a grant, mem_addr, mem_data and mem_src SHALL load the FIFO head and mem_we SHALL be 1 in the following cycle.
REQ-026 No grant: mem_we SHALL be 0 and mem_addr, mem_data and mem_src SHALL hold their values.
REQ-027 Latency: a request sampled at edge k into an empty FIFO with no contention SHALL give mem_we=1 in the cycle after edge k+1, i.e. 2 cycles.
REQ-028 The arbiter SHALL NOT grant a FIFO that is being pushed but was empty before the edge (no bypass).
REQ-029 Ordering: writes from one requester SHALL reach the port in push order; same-address writes from different requesters SHALL NOT be merged and land in grant order.
REQ-030 Throughput: the arbiter SHALL sustain one write per cycle while any FIFO is non-empty.
REQ-031 Overflow flags: once set, overflow[i] SHALL hold until clear_overflow or rst.
REQ-032 Clear vs. drop: if clear_overflow and a new drop coincide on a bit, that bit SHALL read 1 after the edge (set wins).
REQ-033 busy SHALL be the OR of all FIFO non-empty flags, taken from registered state.

Reset
REQ-034 While rst is high at a posedge, all FIFOs SHALL be emptied and rr_ptr, mem_we, mem_addr, mem_data, mem_src, overflow and busy SHALL be 0.
REQ-035 Reset SHALL take priority over every other input, including req_en.
REQ-036 A reset arriving mid-stream SHALL discard all pending entries, and mem_we SHALL be 0 in the cycle after reset is sampled.

Verification
REQ-037 Single request: req_en=3'b001, addr0=8'd22, data0=2'd3 at edge k -> mem_we=1, mem_addr=22, mem_data=3, mem_src=0 after edge k+1; mem_we=0 on the next cycle.
REQ-038 Simultaneous requests: req_en=3'b111 at one edge with addrs 10/20/30 -> three consecutive mem_we cycles with mem_src 0,1,2 and addrs 10,20,30; busy falls after the third grant.
REQ-039 Round-robin fairness: requesters 0 and 2 strobe every cycle for 8 cycles -> grants alternate 0,2,0,2...; overflow[0] and overflow[2] set once their FIFOs fill.
REQ-040 Overflow: req_en[1] for 4 consecutive cycles while requesters 0 and 2 saturate -> overflow[1]=1 and exactly FIFO_DEPTH+1 writes from requester 1 appear; clear_overflow -> overflow=0.
REQ-041 Reset mid-stream: rst with 2 entries queued -> mem_we=0 and busy=0 after reset; no queued write ever appears afterwards.
